// File: rtl/fa_bist_ctrl.sv
// rtl/fa_bist_ctrl.sv - built-in self-test controller for a 1-bit full adder
//
// Applies all eight {c_in,b,a} vectors to an external full adder, holds each for
// SETTLE_CYCLES cycles, compares the adder outputs against a golden model on the
// last settle cycle, counts failing vectors and records the first failing one.
//
// Ports:
//   clk              in   rising-edge clock
//   rst              in   synchronous active-high reset
//   start            in   run request, honoured only in IDLE or DONE
//   dut_sum          in   sum output of the adder under test
//   dut_c_out        in   carry output of the adder under test
//   a, b, c_in       out  registered stimulus to the adder under test
//   busy             out  vectors are being applied
//   done             out  run complete, results valid
//   pass             out  done and no failing vector
//   err_count [3:0]  out  number of failing vectors in the last run (0..8)
//   first_err_valid  out  at least one failing vector recorded
//   first_err_vec    out  {c_in,b,a} of the first failing vector

module fa_bist_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_sum,
  input  logic       dut_c_out,
  output logic       a,
  output logic       b,
  output logic       c_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       first_err_valid,
  output logic [2:0] first_err_vec
);

  // Counter must be at least one bit wide even when SETTLE_CYCLES == 1.
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [2:0]    vec, vec_n;
  logic [CW-1:0] settle_cnt, settle_n;
  logic [3:0]    err_n;
  logic          fev_valid_n;
  logic [2:0]    fev_n;
  logic [2:0]    stim, stim_n;

  logic sum_g;
  logic cout_g;
  logic mismatch;
  logic compare_now;

  // Golden model evaluated on the vector currently presented to the adder.
  assign sum_g    = stim[0] ^ stim[1] ^ stim[2];
  assign cout_g   = (stim[0] & stim[1]) | (stim[0] & stim[2]) | (stim[1] & stim[2]);
  // A vector failing on both outputs still counts as a single failure.
  assign mismatch = (dut_sum != sum_g) || (dut_c_out != cout_g);

  assign compare_now = (state == DRIVE) && (settle_cnt == SETTLE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      vec             <= '0;
      settle_cnt      <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
      stim            <= '0;
    end else begin
      state           <= state_n;
      vec             <= vec_n;
      settle_cnt      <= settle_n;
      err_count       <= err_n;
      first_err_valid <= fev_valid_n;
      first_err_vec   <= fev_n;
      stim            <= stim_n;
    end
  end

  always_comb begin
    state_n     = state;
    vec_n       = vec;
    settle_n    = settle_cnt;
    err_n       = err_count;
    fev_valid_n = first_err_valid;
    fev_n       = first_err_vec;
    stim_n      = stim;

    case (state)
      IDLE, DONE: begin
        // Results from a previous run hold until a new run is accepted.
        if (start) begin
          state_n     = DRIVE;
          vec_n       = 3'd0;
          settle_n    = '0;
          err_n       = 4'd0;
          fev_valid_n = 1'b0;
          fev_n       = 3'd0;
          stim_n      = 3'd0;
        end
      end

      DRIVE: begin
        if (compare_now) begin
          if (mismatch) begin
            err_n = err_count + 4'd1;
            if (!first_err_valid) begin
              fev_valid_n = 1'b1;
              fev_n       = vec;
            end
          end
          if (vec == 3'd7) begin
            state_n = DONE;
            stim_n  = 3'd0;
          end else begin
            vec_n    = vec + 3'd1;
            settle_n = '0;
            stim_n   = vec + 3'd1;
          end
        end else begin
          settle_n = settle_cnt + CW'(1);
        end
      end

      default: begin
        state_n = IDLE;
        stim_n  = 3'd0;
      end
    endcase
  end

  assign {c_in, b, a} = stim;
  assign busy         = (state == DRIVE);
  assign done         = (state == DONE);
  assign pass         = (state == DONE) && (err_count == 4'd0);

endmodule

// File: tb/tb_fa_bist_ctrl.sv
// tb/tb_fa_bist_ctrl.sv - self-checking bench for fa_bist_ctrl

module tb_fa_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic       dut_sum, dut_c_out;
  logic       a, b, c_in, busy, done, pass;
  logic [3:0] err_count;
  logic       first_err_valid;
  logic [2:0] first_err_vec;

  logic       start1;
  logic       sum1, cout1;
  logic       a1, b1, c1, busy1, done1, pass1;
  logic [3:0] err1;
  logic       fv1;
  logic [2:0] fev1;

  int fault;
  int n_tests = 0;
  int n_fail  = 0;

  fa_bist_ctrl #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dut_sum(dut_sum), .dut_c_out(dut_c_out),
    .a(a), .b(b), .c_in(c_in), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_valid(first_err_valid),
    .first_err_vec(first_err_vec)
  );

  fa_bist_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .dut_sum(sum1), .dut_c_out(cout1),
    .a(a1), .b(b1), .c_in(c1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_err_valid(fv1), .first_err_vec(fev1)
  );

  // Adder under test with selectable faults:
  // 0 golden, 1 sum stuck-at-0, 2 c_out inverted, 3 c_out stuck-at-0, 4 both inverted
  always_comb begin
    logic s, c;
    s = a ^ b ^ c_in;
    c = (a & b) | (a & c_in) | (b & c_in);
    dut_sum   = s;
    dut_c_out = c;
    case (fault)
      1: dut_sum = 1'b0;
      2: dut_c_out = ~c;
      3: dut_c_out = 1'b0;
      4: begin dut_sum = ~s; dut_c_out = ~c; end
      default: ;
    endcase
  end

  assign sum1  = a1 ^ b1 ^ c1;
  assign cout1 = (a1 & b1) | (a1 & c1) | (b1 & c1);

  typedef struct {
    int mode;
    bit repulse;
    int exp_err;
    int exp_fev;
    bit exp_fv;
  } vec_t;

  typedef struct {
    int err;
    int fev;
    bit fv;
    bit pass;
  } result_t;

  result_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    result_t r;
    result_t e;
    int j;
    fault = v.mode;
    r.err  = v.exp_err;
    r.fev  = v.exp_fev;
    r.fv   = v.exp_fv;
    r.pass = (v.exp_err == 0);
    exp_q.push_back(r);

    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("clear_err", int'(err_count), 0);
    chk("clear_fv", int'(first_err_valid), 0);
    chk("done_low", int'(done), 0);
    j = 0;
    while (!done && j < 40) begin
      chk("busy", int'(busy), 1);
      chk("stim", int'({c_in, b, a}), j / 2);
      start = v.repulse && (j == 2 || j == 8);
      @(posedge clk);
      #1;
      j++;
    end
    start = 1'b0;
    chk("latency", j, 16);
    chk("busy_end", int'(busy), 0);
    chk("stim_end", int'({c_in, b, a}), 0);

    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: got empty queue expected a result");
    end else begin
      e = exp_q.pop_front();
      chk("err_count", int'(err_count), e.err);
      chk("first_err_vec", int'(first_err_vec), e.fev);
      chk("first_err_valid", int'(first_err_valid), int'(e.fv));
      chk("pass", int'(pass), int'(e.pass));
    end
  endtask

  vec_t tbl[6];

  initial begin
    int j;
    tbl[0] = '{mode: 0, repulse: 1'b0, exp_err: 0, exp_fev: 0, exp_fv: 1'b0};
    tbl[1] = '{mode: 1, repulse: 1'b0, exp_err: 4, exp_fev: 1, exp_fv: 1'b1};
    tbl[2] = '{mode: 2, repulse: 1'b0, exp_err: 8, exp_fev: 0, exp_fv: 1'b1};
    tbl[3] = '{mode: 3, repulse: 1'b0, exp_err: 4, exp_fev: 3, exp_fv: 1'b1};
    tbl[4] = '{mode: 4, repulse: 1'b1, exp_err: 8, exp_fev: 0, exp_fv: 1'b1};
    tbl[5] = '{mode: 1, repulse: 1'b1, exp_err: 4, exp_fev: 1, exp_fv: 1'b1};

    fault  = 0;
    start  = 1'b0;
    start1 = 1'b0;
    rst    = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_stim", int'({c_in, b, a}), 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run(tbl[i]);

    // Results hold in DONE while start stays low.
    repeat (3) @(posedge clk);
    #1;
    chk("hold_done", int'(done), 1);
    chk("hold_err", int'(err_count), 4);
    chk("hold_fev", int'(first_err_vec), 1);

    // Mid-run reset discards partial results (two failures recorded by then).
    fault = 2;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_err", int'(err_count), 2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_pass", int'(pass), 0);
    chk("abort_err", int'(err_count), 0);
    chk("abort_fv", int'(first_err_valid), 0);
    chk("abort_fev", int'(first_err_vec), 0);
    chk("abort_stim", int'({c_in, b, a}), 0);
    run(tbl[0]);

    // Single-cycle settle variant.
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    j = 0;
    while (!done1 && j < 20) begin
      chk("s1_stim", int'({c1, b1, a1}), j);
      @(posedge clk);
      #1;
      j++;
    end
    chk("s1_latency", j, 8);
    chk("s1_pass", int'(pass1), 1);
    chk("s1_err", int'(err1), 0);
    chk("s1_fv", int'(fv1), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
